conv_row_seq: RTL and testbench

- Sequencer for the 3x3 PE convolution array (three 6-bit lanes, 50-bit input window of five 10-bit pixels, 18-bit filter row of three 6-bit taps).
- Holds the 9-tap filter bank and accepts input rows over a valid/ready stream.
- Issues rows to the array one filter row at a time, accumulates the three lane results over 3 passes, and emits one 18-bit result per output row over valid/ready.

---
 rtl/conv_row_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_conv_row_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_row_seq.sv
// ---------------------------------------------------------------------------
// conv_row_seq
//
// Sequencer for a 3x3 PE convolution array. It holds a 9-tap filter bank and
// takes input rows (five 10-bit pixels) over a valid/ready stream. Each row is
// presented to the array with one 3-tap filter row. The three 6-bit lane
// results are accumulated over three passes. Each finished output row is
// emitted as one 18-bit word over valid/ready.
//
// Parameters:
//   PE_LAT   array latency, in cycles, from stable inputs to a valid array_out (>= 1)
//   NUM_OUT  output rows per job (>= 1); each output consumes three input rows
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cfg_we/addr/data      filter tap write; taps 0..8 are writable in IDLE only
//   start                 job start pulse (ignored while a job is running)
//   busy                  high from the accepted start until the done cycle
//   done                  one-cycle pulse after the last output handshake
//   in_valid/ready/data   input row stream (50 bits, five pixels)
//   array_in              input window driven to the array
//   array_filter          filter row driven to the array (tap 3k in [5:0])
//   array_out             three 6-bit lane results returned by the array
//   out_valid/ready/data  accumulated result stream (three 6-bit lanes)
//   sat_flag              (CONV_SAT_EN only) sticky: some lane saturated
//
// Build option:
//   CONV_SAT_EN  when defined, each lane saturates at 63 instead of wrapping,
//                and the sat_flag port is added.
// ---------------------------------------------------------------------------
module conv_row_seq #(
    parameter int PE_LAT  = 1,
    parameter int NUM_OUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [5:0]  cfg_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [49:0] in_data,
    output logic [49:0] array_in,
    output logic [17:0] array_filter,
    input  logic [17:0] array_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_data
`ifdef CONV_SAT_EN
    ,
    output logic        sat_flag
`endif
);

    localparam int LAT_W = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);
    localparam int CNT_W = (NUM_OUT < 1) ? 1 : $clog2(NUM_OUT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PE_LAT);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(NUM_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COMPUTE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [5:0]       taps [0:8];
    logic [49:0]      row_reg;
    logic [17:0]      filt_reg;
    logic [17:0]      row_taps;
    logic [17:0]      acc;
    logic [17:0]      acc_next;
    logic [1:0]       k;
    logic [CNT_W-1:0] out_cnt;
    logic [LAT_W-1:0] lat_cnt;

`ifdef CONV_SAT_EN
    logic [6:0]       lane_sum [3];
    logic [2:0]       lane_sat;
`endif

    logic start_fire;
    logic in_fire;
    logic out_fire;
    logic sample;
    logic last_row;
    logic last_out;
    logic cfg_hit;

    assign start_fire = (state == S_IDLE) && start;
    assign in_fire    = (state == S_FETCH) && in_valid;
    assign out_fire   = (state == S_OUTPUT) && out_ready;
    // The array result is valid once the inputs have been stable for PE_LAT cycles.
    assign sample     = (state == S_COMPUTE) && (lat_cnt == LAT_LAST);
    assign last_row   = (k == 2'd2);
    assign last_out   = (out_cnt == OUT_LAST);
    assign cfg_hit    = cfg_we && (state == S_IDLE) && (cfg_addr <= 4'd8);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: fetch a row, compute it, repeat three times, then emit.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    next_state = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (sample) begin
                    next_state = last_row ? S_OUTPUT : S_FETCH;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    next_state = last_out ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs are pure functions of the state.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            S_IDLE:    ;
            S_FETCH: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            S_COMPUTE: begin
                busy = 1'b1;
            end
            S_OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default:   ;
        endcase
    end

    assign array_in     = row_reg;
    assign array_filter = filt_reg;
    assign out_data     = acc;

    // Filter row selected by the current row index k, with tap 3k in the low lane.
    always_comb begin
        row_taps = '0;
        case (k)
            2'd0:    row_taps = {taps[2], taps[1], taps[0]};
            2'd1:    row_taps = {taps[5], taps[4], taps[3]};
            default: row_taps = {taps[8], taps[7], taps[6]};
        endcase
    end

    // Lane-wise accumulate. The first pass loads the accumulator; later passes
    // add to it independently in each 6-bit lane.
    always_comb begin
        acc_next = acc;
`ifdef CONV_SAT_EN
        lane_sat = '0;
        for (int l = 0; l < 3; l++) begin
            lane_sum[l] = {1'b0, acc[l*6 +: 6]} + {1'b0, array_out[l*6 +: 6]};
        end
        if (k == 2'd0) begin
            acc_next = array_out;
        end else begin
            for (int l = 0; l < 3; l++) begin
                if (lane_sum[l][6]) begin
                    acc_next[l*6 +: 6] = 6'd63;
                    lane_sat[l]        = 1'b1;
                end else begin
                    acc_next[l*6 +: 6] = lane_sum[l][5:0];
                end
            end
        end
`else
        if (k == 2'd0) begin
            acc_next = array_out;
        end else begin
            for (int l = 0; l < 3; l++) begin
                acc_next[l*6 +: 6] = acc[l*6 +: 6] + array_out[l*6 +: 6];
            end
        end
`endif
    end

    // Datapath registers: tap bank, row/filter holding registers, counters and
    // accumulator. The array inputs only change when a new row is accepted, so
    // they stay stable through COMPUTE and hold their values outside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                taps[i] <= '0;
            end
            row_reg  <= '0;
            filt_reg <= '0;
            acc      <= '0;
            k        <= '0;
            out_cnt  <= '0;
            lat_cnt  <= '0;
`ifdef CONV_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            if (cfg_hit) begin
                taps[cfg_addr] <= cfg_data;
            end

            if (start_fire) begin
                k       <= '0;
                out_cnt <= '0;
`ifdef CONV_SAT_EN
                sat_flag <= 1'b0;
`endif
            end

            if (in_fire) begin
                row_reg  <= in_data;
                filt_reg <= row_taps;
                lat_cnt  <= '0;
            end else if ((state == S_COMPUTE) && !sample) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end

            if (sample) begin
                acc <= acc_next;
                if (!last_row) begin
                    k <= k + 2'd1;
                end
`ifdef CONV_SAT_EN
                sat_flag <= sat_flag | (|lane_sat);
`endif
            end

            if (out_fire) begin
                out_cnt <= out_cnt + CNT_W'(1);
                k       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_conv_row_seq.sv
// ---------------------------------------------------------------------------
// tb_conv_row_seq
//
// Self-checking bench for conv_row_seq. The array is modelled as an echo:
// array_out is array_filter delayed by PE_LAT clocks. Because of this, each
// lane of a result is the sum of one tap column. The expected result therefore
// comes straight from the tap bank.
// ---------------------------------------------------------------------------
module tb_conv_row_seq;

    localparam int PE_LAT     = 1;
    localparam int NUM_OUT    = 4;
    localparam int OUT_PERIOD = 3 * (PE_LAT + 2) + 1;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [5:0]  cfg_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [49:0] in_data;
    logic [49:0] array_in;
    logic [17:0] array_filter;
    logic [17:0] array_out;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
`ifdef CONV_SAT_EN
    logic        sat_flag;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [5:0]  tap_m [9];
    logic [17:0] echo_pipe [PE_LAT];

    int          hs;
    int          guard;
    logic [63:0] r64_main;

    conv_row_seq #(
        .PE_LAT  (PE_LAT),
        .NUM_OUT (NUM_OUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .array_in     (array_in),
        .array_filter (array_filter),
        .array_out    (array_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
`ifdef CONV_SAT_EN
        ,
        .sat_flag     (sat_flag)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Echo array: the filter row comes back PE_LAT clocks later.
    always @(posedge clk) begin
        echo_pipe[0] <= array_filter;
        for (int i = 1; i < PE_LAT; i++) begin
            echo_pipe[i] <= echo_pipe[i-1];
        end
    end
    assign array_out = echo_pipe[PE_LAT-1];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One idle-state tap write. The model applies the same address guard as the bank.
    task automatic applyStimulus(input logic [3:0] addr, input logic [5:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        if (addr <= 4'd8) begin
            tap_m[addr] = data;
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // mode 0: taps 1..9, mode 1: all 63, otherwise random.
    task automatic loadTaps(input int mode);
        for (int i = 0; i < 9; i++) begin
            if (mode == 0) begin
                applyStimulus(4'(i), 6'(i + 1));
            end else if (mode == 1) begin
                applyStimulus(4'(i), 6'd63);
            end else begin
                applyStimulus(4'(i), 6'($urandom_range(0, 63)));
            end
        end
    endtask

    // Each lane is the column sum of the tap bank: tap l + tap 3+l + tap 6+l.
    function automatic logic [17:0] refLanes();
        logic [17:0] lanes;
        int total;
        lanes = '0;
        for (int l = 0; l < 3; l++) begin
            total = int'(tap_m[l]) + int'(tap_m[3+l]) + int'(tap_m[6+l]);
`ifdef CONV_SAT_EN
            lanes[l*6 +: 6] = (total > 63) ? 6'd63 : 6'(total);
`else
            lanes[l*6 +: 6] = 6'(total % 64);
`endif
        end
        return lanes;
    endfunction

`ifdef CONV_SAT_EN
    function automatic logic refSat();
        logic s;
        s = 1'b0;
        for (int l = 0; l < 3; l++) begin
            if (int'(tap_m[l]) + int'(tap_m[3+l]) + int'(tap_m[6+l]) > 63) begin
                s = 1'b1;
            end
        end
        return s;
    endfunction
`endif

    function automatic logic [17:0] rowFilter(input int r);
        return {tap_m[3*r+2], tap_m[3*r+1], tap_m[3*r]};
    endfunction

    // Runs a complete job from start to done and checks it cycle by cycle.
    task automatic runJob(input string name, input bit rand_io, input int first_stall,
                          input bit busy_cfg, input bit timing, input bit start_cfg);
        logic [17:0] exp;
        logic [49:0] pend_data;
        logic [63:0] r64;
        logic [3:0]  wa;
        int          cycles;
        int          outs;
        int          rows;
        int          pend_row;
        int          stall_left;
        bit          pend;
        bit          done_seen;

        start     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (start_cfg) begin
            wa       = 4'($urandom_range(0, 8));
            cfg_we   = 1'b1;
            cfg_addr = wa;
            cfg_data = 6'($urandom_range(0, 63));
            tap_m[wa] = cfg_data;
        end
        exp = refLanes();
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
`ifdef CONV_SAT_EN
        checkOutput({name, "/sat_cleared"}, 64'(sat_flag), 64'(0));
`endif

        cycles     = 1;
        outs       = 0;
        rows       = 0;
        pend       = 1'b0;
        pend_row   = 0;
        pend_data  = '0;
        done_seen  = 1'b0;
        stall_left = first_stall;

        while (!done_seen && cycles < 3000) begin
            if (pend) begin
                checkOutput({name, "/array_in"}, 64'(array_in), 64'(pend_data));
                checkOutput({name, "/array_filter"}, 64'(array_filter), 64'(rowFilter(pend_row)));
                checkOutput({name, "/in_ready_compute"}, 64'(in_ready), 64'(0));
                pend = 1'b0;
            end
            if (done) begin
                done_seen = 1'b1;
                checkOutput({name, "/done_busy"}, 64'(busy), 64'(0));
                checkOutput({name, "/outputs"}, 64'(outs), 64'(NUM_OUT));
                if (timing) begin
                    checkOutput({name, "/done_cycle"}, 64'(cycles), 64'(NUM_OUT * OUT_PERIOD + 1));
                end
`ifdef CONV_SAT_EN
                checkOutput({name, "/sat_flag"}, 64'(sat_flag), 64'(refSat()));
`endif
            end else begin
                checkOutput({name, "/busy"}, 64'(busy), 64'(1));
                if (out_valid) begin
                    checkOutput({name, "/out_data"}, 64'(out_data), 64'(exp));
                    checkOutput({name, "/in_ready_out"}, 64'(in_ready), 64'(0));
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                        outs++;
                        if (timing) begin
                            checkOutput({name, "/out_cycle"}, 64'(cycles), 64'(outs * OUT_PERIOD));
                        end
                        stall_left = rand_io ? int'($urandom_range(0, 3)) : 0;
                    end
                end else begin
                    out_ready = rand_io ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                in_valid = rand_io ? ($urandom_range(0, 2) != 0) : 1'b1;
                r64      = {$urandom, $urandom};
                in_data  = r64[49:0];
                start    = rand_io ? 1'($urandom_range(0, 1)) : 1'b0;
                if (busy_cfg) begin
                    cfg_we   = 1'b1;
                    cfg_addr = 4'($urandom_range(0, 8));
                    cfg_data = 6'd5;
                end
                if (in_ready && in_valid) begin
                    pend      = 1'b1;
                    pend_data = in_data;
                    pend_row  = rows % 3;
                    rows++;
                end
            end
            @(negedge clk);
            cycles++;
        end

        start     = 1'b0;
        cfg_we    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput({name, "/done_seen"}, 64'(done_seen), 64'(1));
        checkOutput({name, "/done_pulse_end"}, 64'(done), 64'(0));
        checkOutput({name, "/idle_busy"}, 64'(busy), 64'(0));
        checkOutput({name, "/idle_in_ready"}, 64'(in_ready), 64'(0));
    endtask

    // Directed sequence: reset, basic and throughput, wrap, backpressure,
    // configuration guard, mid-job reset, then randomized jobs.
    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tap_m[i] = '0;
        end
        repeat (3) @(negedge clk);

        checkOutput("reset/busy", 64'(busy), 64'(0));
        checkOutput("reset/done", 64'(done), 64'(0));
        checkOutput("reset/in_ready", 64'(in_ready), 64'(0));
        checkOutput("reset/out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset/out_data", 64'(out_data), 64'(0));
        checkOutput("reset/array_in", 64'(array_in), 64'(0));
        checkOutput("reset/array_filter", 64'(array_filter), 64'(0));
`ifdef CONV_SAT_EN
        checkOutput("reset/sat_flag", 64'(sat_flag), 64'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic taps 1..9 with full-rate streams");
        loadTaps(0);
        runJob("basic", 1'b0, 0, 1'b0, 1'b1, 1'b0);

        $display("[TB] all taps 63");
        loadTaps(1);
        runJob("wrap", 1'b0, 0, 1'b0, 1'b1, 1'b0);

        $display("[TB] output backpressure with tap writes while busy");
        loadTaps(0);
        runJob("backpressure", 1'b0, 5, 1'b1, 1'b0, 1'b0);

        $display("[TB] out-of-range tap addresses in idle");
        applyStimulus(4'd12, 6'd33);
        applyStimulus(4'd15, 6'd7);
        applyStimulus(4'd9, 6'd21);
        runJob("cfg_guard", 1'b1, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during the second compute");
        loadTaps(0);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        hs       = 0;
        guard    = 0;
        while (hs < 2 && guard < 100) begin
            r64_main = {$urandom, $urandom};
            in_data  = r64_main[49:0];
            if (in_ready) begin
                hs++;
            end
            @(negedge clk);
            guard++;
        end
        checkOutput("midreset/reached", 64'(hs), 64'(2));
        checkOutput("midreset/busy_before", 64'(busy), 64'(1));
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midreset/busy", 64'(busy), 64'(0));
        checkOutput("midreset/out_valid", 64'(out_valid), 64'(0));
        checkOutput("midreset/in_ready", 64'(in_ready), 64'(0));
        checkOutput("midreset/done", 64'(done), 64'(0));
        checkOutput("midreset/array_filter", 64'(array_filter), 64'(0));
        checkOutput("midreset/out_data", 64'(out_data), 64'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tap_m[i] = '0;
        end
        @(negedge clk);
        checkOutput("midreset/no_done", 64'(done), 64'(0));
        runJob("after_reset", 1'b0, 0, 1'b0, 1'b1, 1'b0);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 3; j++) begin
            loadTaps(2);
            runJob("random", 1'b1, 0, 1'b0, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
